// File: rtl/mr_pkg.sv
// Shared RV32I decode definitions: operation classes, opcode constants,
// immediate formats and the decoded bundle handed from decode to execute.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMAXLEN
`define IMAXLEN 32
`endif

package mr_pkg;

  typedef enum logic [3:0] {
    OP_ILLEGAL = 4'd0,
    OP_LUI     = 4'd1,
    OP_AUIPC   = 4'd2,
    OP_JAL     = 4'd3,
    OP_JALR    = 4'd4,
    OP_BRANCH  = 4'd5,
    OP_LOAD    = 4'd6,
    OP_STORE   = 4'd7,
    OP_OPIMM   = 4'd8,
    OP_OP      = 4'd9,
    OP_FENCE   = 4'd10,
    OP_SYSTEM  = 4'd11
  } op_t;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [`XLEN-1:0] pc;
    op_t              op;
    logic [2:0]       funct3;
    logic             alt;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             rd_we;
    logic             illegal;
    logic [`XLEN-1:0] imm;
  } bundle_t;

  localparam bundle_t BUNDLE_ZERO = '0;

endpackage

// File: rtl/mr_idecode_if.sv
// Fetch -> decode -> execute handshake bundle plus the writeback flush.
// master = environment (fetch/execute/writeback side), slave = decoder.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMAXLEN
`define IMAXLEN 32
`endif

interface mr_idecode_if import mr_pkg::*; #(
  parameter int XLEN    = `XLEN,
  parameter int IMAXLEN = `IMAXLEN
);
  logic [IMAXLEN-1:0] inst;
  logic [XLEN-1:0]    inst_pc;
  logic               inst_valid;
  logic               id_ready;

  logic               ex_valid;
  logic               ex_ready;
  logic [XLEN-1:0]    ex_pc;
  op_t                ex_op;
  logic [2:0]         ex_funct3;
  logic               ex_alt;
  logic [4:0]         ex_rd;
  logic [4:0]         ex_rs1;
  logic [4:0]         ex_rs2;
  logic               ex_rd_we;
  logic [XLEN-1:0]    ex_imm;
  logic               ex_illegal;

  logic               wb_pc_valid;

  modport master (
    output inst, inst_pc, inst_valid, ex_ready, wb_pc_valid,
    input  id_ready, ex_valid, ex_pc, ex_op, ex_funct3, ex_alt,
           ex_rd, ex_rs1, ex_rs2, ex_rd_we, ex_imm, ex_illegal
  );

  modport slave (
    input  inst, inst_pc, inst_valid, ex_ready, wb_pc_valid,
    output id_ready, ex_valid, ex_pc, ex_op, ex_funct3, ex_alt,
           ex_rd, ex_rs1, ex_rs2, ex_rd_we, ex_imm, ex_illegal
  );
endinterface

// File: rtl/mr_immgen.sv
// Combinational RV32I immediate extraction; every format is sign-extended
// from inst[31]. Only the bits above the opcode field are needed.
`ifndef XLEN
`define XLEN 32
`endif

module mr_immgen import mr_pkg::*; #(
  parameter int XLEN = `XLEN
) (
  input  logic [31:7]     inst,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);

  logic signed [11:0] i_imm;
  logic signed [11:0] s_imm;
  logic signed [12:0] b_imm;
  logic signed [31:0] u_imm;
  logic signed [20:0] j_imm;

  assign i_imm = inst[31:20];
  assign s_imm = {inst[31:25], inst[11:7]};
  assign b_imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm = {inst[31:12], 12'h000};
  assign j_imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Size casts of signed operands perform the sign extension.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = XLEN'(i_imm);
      FMT_S:   imm = XLEN'(s_imm);
      FMT_B:   imm = XLEN'(b_imm);
      FMT_U:   imm = XLEN'(u_imm);
      FMT_J:   imm = XLEN'(j_imm);
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/mr_idecode.sv
// RV32I instruction decode stage, one-cycle latency, valid/ready on both sides.
// Define MR_ID_SKID_EN to add a one-entry skid buffer with a registered id_ready.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMAXLEN
`define IMAXLEN 32
`endif

module mr_idecode import mr_pkg::*; #(
  parameter int XLEN    = `XLEN,
  parameter int IMAXLEN = `IMAXLEN
) (
  input logic         clk,
  input logic         rst,
  mr_idecode_if.slave bus
);

  logic [IMAXLEN-1:0] inst_p0;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [4:0]         rd;
  op_t                op_p0;
  imm_fmt_t           fmt_p0;
  logic               legal_p0;
  logic               writes_p0;
  logic               alt_p0;
  logic [XLEN-1:0]    imm_p0;
  bundle_t            dec_p0;

  assign inst_p0 = bus.inst;
  assign opcode  = inst_p0[6:0];
  assign funct3  = inst_p0[14:12];
  assign funct7  = inst_p0[31:25];
  assign rd      = inst_p0[11:7];

  // ---- stage p0: combinational decode of the fetch word ----
  always_comb begin
    op_p0     = OP_ILLEGAL;
    fmt_p0    = FMT_NONE;
    legal_p0  = 1'b1;
    writes_p0 = 1'b0;
    alt_p0    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        op_p0 = OP_LUI; fmt_p0 = FMT_U; writes_p0 = 1'b1;
      end
      OPC_AUIPC: begin
        op_p0 = OP_AUIPC; fmt_p0 = FMT_U; writes_p0 = 1'b1;
      end
      OPC_JAL: begin
        op_p0 = OP_JAL; fmt_p0 = FMT_J; writes_p0 = 1'b1;
      end
      OPC_JALR: begin
        op_p0 = OP_JALR; fmt_p0 = FMT_I; writes_p0 = 1'b1;
        legal_p0 = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        op_p0 = OP_BRANCH; fmt_p0 = FMT_B;
        legal_p0 = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_LOAD: begin
        op_p0 = OP_LOAD; fmt_p0 = FMT_I; writes_p0 = 1'b1;
        legal_p0 = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OPC_STORE: begin
        op_p0 = OP_STORE; fmt_p0 = FMT_S;
        legal_p0 = (funct3 <= 3'b010);
      end
      OPC_OP_IMM: begin
        op_p0 = OP_OPIMM; fmt_p0 = FMT_I; writes_p0 = 1'b1;
        if (funct3 == 3'b001) begin
          alt_p0   = inst_p0[30];
          legal_p0 = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
          alt_p0   = inst_p0[30];
          legal_p0 = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end
      end
      OPC_OP: begin
        op_p0 = OP_OP; writes_p0 = 1'b1; alt_p0 = inst_p0[30];
        legal_p0 = (funct7 == F7_BASE) ||
                   ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_MISC_MEM: begin
        op_p0 = OP_FENCE; fmt_p0 = FMT_I;
      end
      OPC_SYSTEM: begin
        op_p0 = OP_SYSTEM; fmt_p0 = FMT_I; writes_p0 = 1'b1;
      end
      default: legal_p0 = 1'b0;
    endcase
    if (inst_p0[1:0] != 2'b11) legal_p0 = 1'b0;
  end

  mr_immgen #(.XLEN(XLEN)) u_immgen (
    .inst (inst_p0[31:7]),
    .fmt  (fmt_p0),
    .imm  (imm_p0)
  );

  // Illegal encodings still travel downstream, but with no side effects.
  always_comb begin
    dec_p0        = BUNDLE_ZERO;
    dec_p0.pc     = bus.inst_pc;
    dec_p0.funct3 = funct3;
    dec_p0.rd     = rd;
    dec_p0.rs1    = inst_p0[19:15];
    dec_p0.rs2    = inst_p0[24:20];
    if (legal_p0) begin
      dec_p0.op    = op_p0;
      dec_p0.alt   = alt_p0;
      dec_p0.rd_we = writes_p0 && (rd != 5'd0);
      dec_p0.imm   = imm_p0;
    end else begin
      dec_p0.op      = OP_ILLEGAL;
      dec_p0.illegal = 1'b1;
    end
  end

  // ---- stage p1: output register (and optional skid entry) ----
  bundle_t out_p1;
  logic    vld_p1;
  logic    id_ready;
  logic    in_fire;
  logic    out_free;
  logic    flush;

  assign flush    = bus.wb_pc_valid;
  assign out_free = !vld_p1 || bus.ex_ready;
  assign in_fire  = bus.inst_valid && id_ready && !flush;

`ifdef MR_ID_SKID_EN
  bundle_t skid_p1;
  logic    skid_vld_p1;

  // Ready comes straight from a flop, so fetch never sees ex_ready combinationally.
  assign id_ready = !skid_vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      out_p1      <= BUNDLE_ZERO;
      skid_p1     <= BUNDLE_ZERO;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (out_free) begin
      if (skid_vld_p1) begin
        out_p1      <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= in_fire;
        if (in_fire) out_p1 <= dec_p0;
      end
    end else if (in_fire) begin
      skid_p1     <= dec_p0;
      skid_vld_p1 <= 1'b1;
    end
  end
`else
  assign id_ready = out_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      out_p1 <= BUNDLE_ZERO;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (out_free) begin
      vld_p1 <= in_fire;
      if (in_fire) out_p1 <= dec_p0;
    end
  end
`endif

  assign bus.id_ready   = id_ready;
  assign bus.ex_valid   = vld_p1;
  assign bus.ex_pc      = out_p1.pc;
  assign bus.ex_op      = out_p1.op;
  assign bus.ex_funct3  = out_p1.funct3;
  assign bus.ex_alt     = out_p1.alt;
  assign bus.ex_rd      = out_p1.rd;
  assign bus.ex_rs1     = out_p1.rs1;
  assign bus.ex_rs2     = out_p1.rs2;
  assign bus.ex_rd_we   = out_p1.rd_we;
  assign bus.ex_imm     = out_p1.imm;
  assign bus.ex_illegal = out_p1.illegal;

endmodule

// File: doc/mr_idecode.md
MR_IDECODE -- requirements
Module: mr_idecode

Interface
REQ-001 Parameter XLEN, default `XLEN (32), datapath and PC width; IMAXLEN, default `IMAXLEN (32), instruction width.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 inst  input  IMAXLEN  instruction word from fetch.
REQ-005 inst_pc  input  XLEN  PC of inst.
REQ-006 inst_valid  input  1  inst/inst_pc valid.
REQ-007 id_ready  output  1  decode can accept this cycle.
REQ-008 ex_valid  output  1  decoded bundle valid.
REQ-009 ex_ready  input  1  execute accepts bundle.
REQ-010 ex_pc  output  XLEN  PC of decoded instruction.
REQ-011 ex_op  output  op_t  operation class.
REQ-012 ex_funct3 / ex_alt  output  3 / 1  funct3; inst[30] for OP, shift-imm and SRAI, else 0.
REQ-013 ex_rd, ex_rs1, ex_rs2  output  5 each  register indices.
REQ-014 ex_rd_we  output  1  rd written.
REQ-015 ex_imm  output  XLEN  sign-extended immediate.
REQ-016 ex_illegal  output  1  illegal encoding.
REQ-017 wb_pc_valid  input  1  redirect/flush from writeback.

Function
REQ-018 Transfer in on inst_valid && id_ready; out on ex_valid && ex_ready; latency one cycle.
REQ-019 While ex_valid && !ex_ready, all ex_* outputs SHALL hold stable.
REQ-020 ex_op SHALL be LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, FENCE (MISC_MEM), SYSTEM or ILLEGAL.
REQ-021 ex_imm SHALL be I/S/B/U/J format per opcode, sign-extended from inst[31]; OP, ILLEGAL: 0.
REQ-022 ex_rd_we SHALL be 1 only for LUI/AUIPC/JAL/JALR/LOAD/OP_IMM/OP/SYSTEM with rd!=0.
REQ-023 Illegal: inst[1:0]!=2'b11; unknown opcode; BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3>010; JALR funct3!=0; OP funct7 not 0x00/0x20, or 0x20 with funct3 not 000/101; SLLI funct7!=0; SRLI/SRAI funct7 not 0x00/0x20.
REQ-024 Illegal instructions SHALL still pass downstream: ex_op=ILLEGAL, ex_illegal=1, ex_rd_we=0.
REQ-025 wb_pc_valid SHALL clear ex_valid and skid next cycle and suppress capture of same-cycle input; wins over all simultaneous transfers.
REQ-026 Simultaneous in/out transfer SHALL replace the bundle without bubble.

Reset
REQ-027 On rst: ex_valid=0, skid empty, all ex_* payload 0 (ex_op=ILLEGAL encoding 0 not required; payload value 0), id_ready=1 from the cycle after reset.
REQ-028 rst mid-stall SHALL discard held and skid bundles.

Configuration
REQ-029 Macro MR_ID_SKID_EN.
REQ-030 Defined: one-entry skid buffer; id_ready registered, =!skid_valid; accepted input while stalled goes to skid; skid moves to output when ex_ready; maximum two instructions held.
REQ-031 Undefined: no skid; id_ready = !ex_valid || ex_ready combinationally.

Structure
REQ-032 Shared package mr_pkg: op_t enum, RV32I opcode constants, decoded-bundle struct.
REQ-033 Sub-module mr_immgen: combinational immediate extraction (inst, format -> imm).

Verification
REQ-034 inst=0xFFF10093 (addi x1,x2,-1), ex_ready=1 -> next cycle ex_op=OP_IMM, rd=1, rs1=2, imm=0xFFFFFFFF, rd_we=1.
REQ-035 inst=0x00512423 (sw x5,8(x2)) -> ex_op=STORE, rs1=2, rs2=5, imm=8, rd_we=0, illegal=0.
REQ-036 inst=0x00000000 -> ex_illegal=1, ex_op=ILLEGAL, rd_we=0.
REQ-037 Stream PCs 0x0,0x4,0x8,0xC; ex_ready=0 for 3 cycles mid-stream -> all four delivered in order once, none dropped/duplicated; with MR_ID_SKID_EN id_ready drops after two held.
REQ-038 wb_pc_valid=1 while ex_valid=1 and inst_valid=1 -> next cycle ex_valid=0, skid empty, flushed input never appears.
REQ-039 rst asserted during stall with two held -> next cycle ex_valid=0, id_ready=1, then normal operation.
